// File: rtl/div_pkg.sv
// Shared state type and sizing constants for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int unsigned DIV_WIDTH = 32;

  // Divide-by-zero quotient pattern (all ones).
  localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOT = '1;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {R,Q} left, subtract, restore.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] q_sh;

  always_comb begin
    r_sh  = {r_i, q_i[WIDTH-1]};
    q_sh  = {q_i[WIDTH-2:0], 1'b0};
    trial = r_sh - {2'b00, divisor_i};
    if (trial[WIDTH+1]) begin
      r_o = r_sh[WIDTH:0];
      q_o = q_sh;
    end else begin
      r_o = trial[WIDTH:0];
      q_o = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle DIV/DIVU unit: WIDTH restoring steps, then signed fix-up into LO/HI.
module iterative_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_cancel,
  output logic             DIV_Busy,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned      CNT_W    = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] DZ_QUOT  =
    WIDTH'({((WIDTH + DIV_WIDTH - 1) / DIV_WIDTH){DIV_DZ_QUOT}});

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q;
  logic             q_neg_q, r_neg_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic             accept;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_i      (r_q),
    .q_i      (q_q),
    .divisor_i(dvsr_q),
    .r_o      (r_d),
    .q_o      (q_d)
  );

  always_comb begin
    dividend_abs = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs  = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    quot_fix     = q_neg_q ? -q_d : q_d;
    rem_fix      = r_neg_q ? -r_d[WIDTH-1:0] : r_d[WIDTH-1:0];
    accept       = div_start && !div_cancel && (state_q != CALC);
    DIV_Busy     = (state_q == CALC) || ((state_q == IDLE) && accept);
  end

  // Results are written on the edge that enters DONE, using the final step's
  // combinational output, so they are valid in the same cycle as div_done.
  // With a zero divisor R ends as |dividend|, so the remainder fix-up
  // reproduces the dividend as issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (div_cancel) begin
        state_q <= IDLE;
      end else if (accept) begin
        r_q     <= '0;
        q_q     <= dividend_abs;
        dvsr_q  <= divisor_abs;
        q_neg_q <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg_q <= div_signed && dividend[WIDTH-1];
        cnt_q   <= CNT_INIT;
        state_q <= CALC;
      end else if (state_q == CALC) begin
        r_q   <= r_d;
        q_q   <= q_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          quot_q  <= (dvsr_q == '0) ? DZ_QUOT : quot_fix;
          rem_q   <= rem_fix;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign div_done  = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule
